// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the memory-side blocks of the core.
//   XLEN        : data/address width of the core
//   arb_state_e : memory arbiter transaction phase (IDLE, REQ, RESP)
//   owner_e     : which requester owns the outstanding memory transaction
//   SIZE_WORD   : access size code used for instruction fetches
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] SIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-outstanding memory port between the instruction fetch
// and the data (load/store) requesters. Data normally wins, but after
// MAX_D_STREAK consecutive data grants a waiting fetch is forced through.
//
// Ports
//   clk, reset                       : clock, asynchronous active-high reset
//   if_req_i, if_adr_i, if_kill_i    : fetch request / address / flush
//   if_gnt_o, if_rvalid_o, if_rdata_o: fetch accepted / data valid / instruction
//   d_req_i, d_we_i, d_adr_i,
//   d_wdata_i, d_size_i              : data request, store flag, address, data, size
//   d_gnt_o, d_rvalid_o, d_rdata_o   : data accepted / response valid / load data
//   mem_req_o, mem_we_o, mem_adr_o,
//   mem_wdata_o, mem_size_o          : memory request fields
//   mem_gnt_i, mem_rvalid_i,
//   mem_rdata_i                      : memory accept / response valid / read data
module mem_arbiter #(
    parameter int XLEN         = riscv_pkg::XLEN,
    parameter int MAX_D_STREAK = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_adr_i,
    input  logic            if_kill_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [31:0]     if_rdata_o,
    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [XLEN-1:0] d_adr_i,
    input  logic [XLEN-1:0] d_wdata_i,
    input  logic [2:0]      d_size_i,
    output logic            d_gnt_o,
    output logic            d_rvalid_o,
    output logic [XLEN-1:0] d_rdata_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_adr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [2:0]      mem_size_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);
    import riscv_pkg::*;

    localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    arb_state_e      state;
    owner_e          owner;
    logic            drop;
    logic [SW-1:0]   streak;
    logic [XLEN-1:0] lat_adr;
    logic [XLEN-1:0] lat_wdata;
    logic            lat_we;
    logic [2:0]      lat_size;

    logic            fetch_ok;
    logic            pick_if;
    logic            issue;
    logic            cur_is_if;
    logic            gnt_accept;
    logic            resp;
    logic [XLEN-1:0] sel_adr;
    logic [XLEN-1:0] sel_wdata;
    logic            sel_we;
    logic [2:0]      sel_size;

    // Arbitration and output decode. Issue, grant and response are all
    // gated by reset so every output reads zero while reset is held, even
    // if requesters keep their request lines up.
    always_comb begin
        fetch_ok  = if_req_i && !if_kill_i;
        pick_if   = fetch_ok && (!d_req_i || streak == STREAK_MAX);
        issue     = !reset && state == ST_IDLE && (fetch_ok || d_req_i);
        cur_is_if = (state == ST_IDLE) ? pick_if : (owner == OWN_IF);

        sel_adr   = pick_if ? if_adr_i : d_adr_i;
        sel_wdata = pick_if ? '0 : d_wdata_i;
        sel_we    = pick_if ? 1'b0 : d_we_i;
        sel_size  = pick_if ? SIZE_WORD : d_size_i;

        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_adr_o   = '0;
        mem_wdata_o = '0;
        mem_size_o  = '0;
        if (issue) begin
            mem_req_o   = 1'b1;
            mem_we_o    = sel_we;
            mem_adr_o   = sel_adr;
            mem_wdata_o = sel_wdata;
            mem_size_o  = sel_size;
        end else if (!reset && state == ST_REQ) begin
            mem_req_o   = 1'b1;
            mem_we_o    = lat_we;
            mem_adr_o   = lat_adr;
            mem_wdata_o = lat_wdata;
            mem_size_o  = lat_size;
        end

        gnt_accept = mem_gnt_i && mem_req_o;
        if_gnt_o   = gnt_accept && cur_is_if;
        d_gnt_o    = gnt_accept && !cur_is_if;

        // A kill arriving in the same cycle as the response also drops it.
        resp        = !reset && state == ST_RESP && mem_rvalid_i;
        if_rvalid_o = resp && owner == OWN_IF && !drop && !if_kill_i;
        d_rvalid_o  = resp && owner == OWN_D;
        if_rdata_o  = if_rvalid_o ? mem_rdata_i[31:0] : 32'h0;
        d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;
    end

    // Transaction FSM plus the request latch, drop flag and data streak.
    // The latch captures the winner's fields at issue so the memory side
    // sees stable values for however long it stalls the grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= OWN_IF;
            drop      <= 1'b0;
            streak    <= '0;
            lat_adr   <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            lat_size  <= '0;
        end else begin
            if (if_gnt_o) begin
                streak <= '0;
            end else if (d_gnt_o && streak != STREAK_MAX) begin
                streak <= streak + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    drop <= 1'b0;
                    if (issue) begin
                        owner     <= pick_if ? OWN_IF : OWN_D;
                        lat_adr   <= sel_adr;
                        lat_wdata <= sel_wdata;
                        lat_we    <= sel_we;
                        lat_size  <= sel_size;
                        state     <= mem_gnt_i ? ST_RESP : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (owner == OWN_IF && if_kill_i) begin
                        drop <= 1'b1;
                    end
                    if (mem_gnt_i) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (owner == OWN_IF && if_kill_i) begin
                        drop <= 1'b1;
                    end
                    if (mem_rvalid_i) begin
                        drop  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
